// File: rtl/enc_pkg.sv
// Shared constants and FSM state type for the active-low request encoder.
// The optional round-robin build is selected with REQ_ENCODER_RR_EN.
package enc_pkg;

    localparam int N_REQ  = 8;
    localparam int CODE_W = 3;

    // Only this enable code arms request capture.
    localparam logic [1:0] ENA_CAPTURE = 2'b10;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

endpackage

// File: rtl/prio_pick.sv
// Combinational picker: fixed priority (highest index wins) by default, or a
// round-robin search starting at base and wrapping 7->0 under REQ_ENCODER_RR_EN.
module prio_pick (
    input  logic [enc_pkg::N_REQ-1:0]  pend,
    input  logic [enc_pkg::CODE_W-1:0] base,
    output logic [enc_pkg::CODE_W-1:0] idx,
    output logic                       any
);
    import enc_pkg::*;

    always_comb begin
        // NOTE: default first so every path assigns idx and no latch is inferred.
        idx = '0;
`ifdef REQ_ENCODER_RR_EN
        // Walk offsets downwards so the smallest offset from base wins.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (pend[base + CODE_W'(k)]) begin
                idx = base + CODE_W'(k);
            end
        end
`else
        for (int i = 0; i < N_REQ; i++) begin
            if (pend[i]) begin
                idx = CODE_W'(i);
            end
        end
`endif
    end

`ifndef REQ_ENCODER_RR_EN
    logic w_unused_base;
    assign w_unused_base = ^base;
`endif

    assign any = |pend;

endmodule

// File: rtl/req_encoder.sv
// Edge-captured active-low request encoder with a grant/ack handshake.
// Define REQ_ENCODER_RR_EN for round-robin selection instead of fixed priority.
module req_encoder #(
    parameter int N_REQ = 8
) (
    input  logic                       iClk,
    input  logic                       iRst_n,
    input  logic [N_REQ-1:0]           iReq,
    input  logic [1:0]                 iEna,
    input  logic                       iAck,
    output logic [enc_pkg::CODE_W-1:0] oData,
    output logic                       oValid,
    output logic                       oGS_n,
    output logic [N_REQ-1:0]           oPend
);
    import enc_pkg::*;

    state_t              r_state;
    logic [N_REQ-1:0]    r_pend;
    logic [N_REQ-1:0]    r_req_prev;
    logic [CODE_W-1:0]   r_data;
    logic                r_valid;
    logic                r_gs_n;

    logic [N_REQ-1:0]    w_capture;
    logic [N_REQ-1:0]    w_clear;
    logic [N_REQ-1:0]    w_pend_next;
    logic [CODE_W-1:0]   w_base;
    logic [CODE_W-1:0]   w_idx;
    logic                w_any;

`ifdef REQ_ENCODER_RR_EN
    logic [CODE_W-1:0]   r_ptr;
    assign w_base = r_ptr;
`else
    assign w_base = '0;
`endif

    // A falling edge on a line arms it; holding the line low does not re-arm.
    assign w_capture   = (iEna == ENA_CAPTURE) ? (r_req_prev & ~iReq) : '0;
    assign w_clear     = (r_state == GRANT && iAck) ? (N_REQ'(1) << r_data) : '0;
    // A fresh capture on the bit being acknowledged survives the clear.
    assign w_pend_next = (r_pend & ~w_clear) | w_capture;

    prio_pick u_pick (
        .pend (r_pend),
        .base (w_base),
        .idx  (w_idx),
        .any  (w_any)
    );

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            r_state    <= IDLE;
            r_pend     <= '0;
            r_req_prev <= '1;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_gs_n     <= 1'b1;
`ifdef REQ_ENCODER_RR_EN
            r_ptr      <= '0;
`endif
        end else begin
            r_req_prev <= iReq;
            r_pend     <= w_pend_next;
            r_gs_n     <= ~|w_pend_next;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_state <= GRANT;
                        r_data  <= w_idx;
                        r_valid <= 1'b1;
                    end
                end
                GRANT: begin
                    if (iAck) begin
                        r_state <= IDLE;
                        r_valid <= 1'b0;
`ifdef REQ_ENCODER_RR_EN
                        r_ptr   <= r_data + CODE_W'(1);
`endif
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign oData  = r_data;
    assign oValid = r_valid;
    assign oGS_n  = r_gs_n;
    assign oPend  = r_pend;

endmodule

// File: tb/tb_req_encoder.sv
// Self-checking bench for req_encoder: directed scenarios plus random stimulus
// against a behavioural model; round-robin checks run under REQ_ENCODER_RR_EN.
module tb_req_encoder;

    logic       iClk   = 1'b0;
    logic       iRst_n = 1'b0;
    logic [7:0] iReq   = 8'hFF;
    logic [1:0] iEna   = 2'b00;
    logic       iAck   = 1'b0;
    logic [2:0] oData;
    logic       oValid;
    logic       oGS_n;
    logic [7:0] oPend;

    int n_vec = 0;
    int n_err = 0;

    req_encoder #(.N_REQ(8)) dut (
        .iClk   (iClk),
        .iRst_n (iRst_n),
        .iReq   (iReq),
        .iEna   (iEna),
        .iAck   (iAck),
        .oData  (oData),
        .oValid (oValid),
        .oGS_n  (oGS_n),
        .oPend  (oPend)
    );

    always #5 iClk = ~iClk;

    // Reference model: one flag per request line plus the handshake state.
    bit m_pend[8];
    bit m_prev[8];
    bit m_valid;
    int m_data;
    int m_ptr;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] pend_word();
        logic [7:0] w = 8'h00;
        for (int i = 0; i < 8; i++) if (m_pend[i]) w = w + 8'(1 << i);
        return w;
    endfunction

    function automatic int pick();
`ifdef REQ_ENCODER_RR_EN
        for (int k = 0; k < 8; k++) if (m_pend[(m_ptr + k) % 8]) return (m_ptr + k) % 8;
`else
        for (int i = 7; i >= 0; i--) if (m_pend[i]) return i;
`endif
        return 0;
    endfunction

    task automatic model_edge(input logic [7:0] req, input logic [1:0] ena,
                              input logic ack, input logic rst_n);
        bit nxt[8];
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                m_pend[i] = 1'b0;
                m_prev[i] = 1'b1;
            end
            m_valid = 1'b0;
            m_data  = 0;
            m_ptr   = 0;
            return;
        end
        nxt = m_pend;
        if (m_valid && ack) nxt[m_data] = 1'b0;
        for (int i = 0; i < 8; i++)
            if (ena == 2'b10 && m_prev[i] && !req[i]) nxt[i] = 1'b1;
        if (!m_valid) begin
            if (pend_word() != 8'h00) begin
                m_data  = pick();
                m_valid = 1'b1;
            end
        end else if (ack) begin
            m_valid = 1'b0;
            m_ptr   = (m_data + 1) % 8;
        end
        m_pend = nxt;
        for (int i = 0; i < 8; i++) m_prev[i] = req[i];
    endtask

    task automatic step(input logic [7:0] req, input logic [1:0] ena,
                        input logic ack, input logic rst_n = 1'b1);
        iReq   = req;
        iEna   = ena;
        iAck   = ack;
        iRst_n = rst_n;
        @(posedge iClk);
        model_edge(req, ena, ack, rst_n);
        #1;
        check("pend",  oPend,           pend_word());
        check("valid", {7'b0, oValid},  {7'b0, m_valid});
        check("data",  {5'b0, oData},   8'(m_data));
        check("gs_n",  {7'b0, oGS_n},   {7'b0, (pend_word() == 8'h00)});
    endtask

    initial begin
        int exp30[4] = '{6, 4, 3, 1};

        step(8'hFF, 2'b00, 1'b0, 1'b0);
        step(8'hFF, 2'b00, 1'b0, 1'b0);
        check("rst_pend",  oPend,          8'h00);
        check("rst_valid", {7'b0, oValid}, 8'h00);
        check("rst_gs_n",  {7'b0, oGS_n},  8'h01);

        // Single request on line 3.
        step(8'hFF, 2'b10, 1'b0);
        step(8'hF7, 2'b10, 1'b0);
        check("t29_pend", oPend, 8'h08);
        step(8'hF7, 2'b10, 1'b0);
        check("t29_valid", {7'b0, oValid}, 8'h01);
        check("t29_data",  {5'b0, oData},  8'h03);
        step(8'hF7, 2'b10, 1'b1);
        check("t29_ack_valid", {7'b0, oValid}, 8'h00);
        check("t29_ack_pend",  oPend,          8'h00);

        // Lines 6,4,3,1 fall together (active-low pattern A5); priority order follows.
        step(8'hFF, 2'b10, 1'b0);
        step(8'hA5, 2'b10, 1'b0);
        check("t30_pend", oPend, 8'h5A);
        for (int g = 0; g < 4; g++) begin
            for (int w = 0; w < 4 && !oValid; w++) step(8'hA5, 2'b10, 1'b0);
            check("t30_valid", {7'b0, oValid}, 8'h01);
            check("t30_data",  {5'b0, oData},  8'(exp30[g]));
            step(8'hA5, 2'b10, 1'b1);
            check("t30_gap", {7'b0, oValid}, 8'h00);
        end

        // Capture disabled, then enabled with the line still held low.
        step(8'hFF, 2'b10, 1'b0);
        step(8'hFE, 2'b01, 1'b0);
        check("t31_pend", oPend,         8'h00);
        check("t31_gs_n", {7'b0, oGS_n}, 8'h01);
        step(8'hFE, 2'b01, 1'b0);
        step(8'hFE, 2'b10, 1'b0);
        step(8'hFE, 2'b10, 1'b0);
        check("t31_late_pend", oPend,         8'h00);
        check("t31_late_gs_n", {7'b0, oGS_n}, 8'h01);

        // Re-request of line 2 lands on the ack edge of its own grant.
        step(8'hFF, 2'b10, 1'b0);
        step(8'hFB, 2'b10, 1'b0);
        step(8'hFB, 2'b10, 1'b0);
        check("t32_data", {5'b0, oData}, 8'h02);
        step(8'hFF, 2'b10, 1'b0);
        step(8'hFB, 2'b10, 1'b1);
        check("t32_keep",  {7'b0, oPend[2]}, 8'h01);
        check("t32_valid", {7'b0, oValid},   8'h00);
        step(8'hFB, 2'b10, 1'b0);
        check("t32_regrant_valid", {7'b0, oValid}, 8'h01);
        check("t32_regrant_data",  {5'b0, oData},  8'h02);
        step(8'hFB, 2'b10, 1'b1);

        // Reset while line 5 is being presented.
        step(8'hFF, 2'b10, 1'b0);
        step(8'hDF, 2'b10, 1'b0);
        step(8'hDF, 2'b10, 1'b0);
        check("t33_data",  {5'b0, oData},  8'h05);
        check("t33_valid", {7'b0, oValid}, 8'h01);
        step(8'hFF, 2'b10, 1'b0, 1'b0);
        check("t33_rst_pend",  oPend,          8'h00);
        check("t33_rst_valid", {7'b0, oValid}, 8'h00);
        check("t33_rst_data",  {5'b0, oData},  8'h00);
        check("t33_rst_gs_n",  {7'b0, oGS_n},  8'h01);
        step(8'hFF, 2'b10, 1'b0);

`ifdef REQ_ENCODER_RR_EN
        begin
            int exp34[4] = '{0, 7, 0, 7};
            int got34[4];
            int ng = 0;
            logic last_v = 1'b0;
            for (int s = 0; s < 40 && ng < 4; s++) begin
                step((s % 2) ? 8'h7E : 8'hFF, 2'b10, m_valid);
                if (oValid && !last_v) begin
                    got34[ng] = int'(oData);
                    ng++;
                end
                last_v = oValid;
            end
            check("t34_count", 8'(ng), 8'd4);
            for (int g = 0; g < ng; g++) check("t34_grant", 8'(got34[g]), 8'(exp34[g]));
            step(8'hFF, 2'b10, 1'b0, 1'b0);
        end
`endif

        // Random traffic, including occasional resets and acks while idle.
        for (int n = 0; n < 400; n++) begin
            step(8'($urandom),
                 ($urandom_range(0, 1) != 0) ? 2'b10 : 2'($urandom),
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 49) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
